// File: rtl/tc_rom_loader_pkg.sv
// Shared definitions for the ROM image loader: FSM state encoding and
// byte/word geometry helpers.
package tc_rom_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam int DEFAULT_BIT_WIDTH = 16;
    localparam int BYTES_PER_WORD    = DEFAULT_BIT_WIDTH / 8;

    function automatic int bytes_per_word(input int bit_width);
        return bit_width / 8;
    endfunction

    // A one-byte word still needs a 1-bit index so the counter has a legal width.
    function automatic int index_width(input int bpw);
        return (bpw > 1) ? $clog2(bpw) : 1;
    endfunction

endpackage

// File: rtl/tc_byte_packer.sv
// Little-endian byte-to-word assembler: byte index counter, assembly register
// and a flag marking the byte slot that completes the word.
module tc_byte_packer
    import tc_rom_loader_pkg::*;
#(
    parameter int BPW = BYTES_PER_WORD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [7:0]       i_byte,
    output logic [8*BPW-1:0] o_word_next,
    output logic             o_word_full
);

    localparam int IDX_W = index_width(BPW);

    logic [IDX_W-1:0] r_idx;
    logic [8*BPW-1:0] r_word;
    logic [8*BPW-1:0] w_word_next;

    // o_word_next already contains the byte being loaded, so the caller can
    // capture a completed word on the same edge the last byte arrives.
    for (genvar gi = 0; gi < BPW; gi++) begin : g_lane
        assign w_word_next[8*gi +: 8] = (i_load && (r_idx == IDX_W'(gi))) ? i_byte
                                                                          : r_word[8*gi +: 8];
    end

    assign o_word_next = w_word_next;
    assign o_word_full = (r_idx == IDX_W'(BPW - 1));

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_idx  <= '0;
            r_word <= '0;
        end else if (i_load) begin
            r_word <= w_word_next;
            r_idx  <= o_word_full ? '0 : r_idx + 1'b1;
        end
    end

endmodule

// File: rtl/tc_rom_loader.sv
// Streams image bytes into BIT_WIDTH-wide words and writes them to a memory
// save port, one word per WRITE cycle, until the image ends or memory fills.
module tc_rom_loader
    import tc_rom_loader_pkg::*;
#(
    parameter int BIT_WIDTH = 16,
    parameter int BIT_DEPTH = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 byte_valid,
    input  logic [7:0]           byte_data,
    input  logic                 byte_last,
    output logic                 byte_ready,
    output logic                 mem_save,
    output logic [15:0]          mem_address,
    output logic [BIT_WIDTH-1:0] mem_in,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          word_count
);

    localparam int BPW = bytes_per_word(BIT_WIDTH);

    state_t               r_state;
    logic                 r_byte_ready;
    logic                 r_mem_save;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_last_seen;
    logic [BIT_WIDTH-1:0] r_mem_in;
    logic [15:0]          r_word_count;

    logic                 w_xfer;
    logic                 w_start_ok;
    logic                 w_clear;
    logic                 w_word_full;
    logic [BIT_WIDTH-1:0] w_word_next;

    assign w_xfer     = byte_valid && r_byte_ready;
    assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    // Leaving WRITE always starts a fresh word, so the packer is wiped then too.
    assign w_clear    = w_start_ok || (r_state == ST_WRITE);

    tc_byte_packer #(
        .BPW (BPW)
    ) u_packer (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_clear),
        .i_load      (w_xfer),
        .i_byte      (byte_data),
        .o_word_next (w_word_next),
        .o_word_full (w_word_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_byte_ready <= 1'b0;
            r_mem_save   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_last_seen  <= 1'b0;
            r_mem_in     <= '0;
            r_word_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state      <= ST_COLLECT;
                        r_word_count <= '0;
                        r_byte_ready <= 1'b1;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_last_seen  <= 1'b0;
                    end
                end
                ST_COLLECT: begin
                    if (w_xfer && (w_word_full || byte_last)) begin
                        r_state      <= ST_WRITE;
                        r_byte_ready <= 1'b0;
                        r_mem_save   <= 1'b1;
                        r_mem_in     <= w_word_next;
                        r_last_seen  <= byte_last;
                    end
                end
                ST_WRITE: begin
                    r_mem_save   <= 1'b0;
                    r_mem_in     <= '0;
                    r_word_count <= r_word_count + 16'd1;
                    if (r_last_seen || ((r_word_count + 16'd1) == 16'(BIT_DEPTH))) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state      <= ST_COLLECT;
                        r_byte_ready <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Address tracks the count; during WRITE it is still the pre-increment value.
    assign mem_address = r_word_count;
    assign word_count  = r_word_count;
    assign byte_ready  = r_byte_ready;
    assign mem_save    = r_mem_save;
    assign mem_in      = r_mem_in;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule

// File: tb/tb_tc_rom_loader.sv
// Scoreboard bench for tc_rom_loader: three geometries run in parallel, each
// with its own driver, reference model and write monitor.
module tb_tc_rom_loader;

    localparam int NCFG = 3;

    function automatic int cfg_w(input int i);
        case (i)
            0:       return 16;
            1:       return 8;
            default: return 32;
        endcase
    endfunction

    function automatic int cfg_d(input int i);
        return (i == 1) ? 4 : 256;
    endfunction

    logic clk = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
        localparam int W = cfg_w(gi);
        localparam int D = cfg_d(gi);
        localparam int B = W / 8;

        logic          rst, start, bv, bl;
        logic [7:0]    bd;
        logic          br, ms, busy, done;
        logic [15:0]   ma, wc;
        logic [W-1:0]  mi;
        bit            fin    = 1'b0;
        bit            mon_en = 1'b0;
        bit            prev_ms = 1'b0;
        int unsigned   exp_addr[$];
        logic [63:0]   exp_data[$];

        tc_rom_loader #(
            .BIT_WIDTH (W),
            .BIT_DEPTH (D)
        ) dut (
            .clk         (clk),
            .rst         (rst),
            .start       (start),
            .byte_valid  (bv),
            .byte_data   (bd),
            .byte_last   (bl),
            .byte_ready  (br),
            .mem_save    (ms),
            .mem_address (ma),
            .mem_in      (mi),
            .busy        (busy),
            .done        (done),
            .word_count  (wc)
        );

        function automatic string nm(input string s);
            return $sformatf("c%0d_%s", gi, s);
        endfunction

        always @(negedge clk) begin
            if (mon_en) begin
                if (ms) begin
                    if (exp_addr.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL %s actual=addr %0d data 0x%0h required=no write",
                                 nm("unexpected_write"), ma, mi);
                    end else begin
                        check(nm("write_addr"), 64'(ma), 64'(exp_addr.pop_front()));
                        check(nm("write_data"), 64'(mi), exp_data.pop_front());
                    end
                    check(nm("save_one_cycle"), 64'(prev_ms), 64'd0);
                end else begin
                    check(nm("idle_mem_in"), 64'(mi), 64'd0);
                    check(nm("idle_addr"), 64'(ma), 64'(wc));
                end
                prev_ms = ms;
            end
        end

        task automatic pulse_start();
            @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        endtask

        task automatic run_load(input logic [7:0] img[$], input bit has_last,
                                input int mode, input bit poke);
            int nb, nw, consumed, i, cyc, lim;
            bit v, xfer;
            nb       = img.size();
            nw       = (nb + B - 1) / B;
            if (nw > D) nw = D;
            consumed = (nb < D * B) ? nb : D * B;
            lim      = 8 * nb + 64;
            for (int w = 0; w < nw; w++) begin
                logic [63:0] d;
                d = '0;
                for (int k = 0; k < B; k++)
                    if (w * B + k < nb) d[8*k +: 8] = img[w * B + k];
                exp_addr.push_back(w);
                exp_data.push_back(d);
            end
            pulse_start();
            check(nm("start_count"), 64'(wc), 64'd0);
            check(nm("start_flags"), {61'd0, busy, done, br}, 64'b101);
            i   = 0;
            cyc = 0;
            while (i < consumed && cyc < lim) begin
                case (mode)
                    0:       v = 1'b1;
                    1:       v = cyc[0];
                    default: v = 1'($urandom_range(0, 1));
                endcase
                bv    = v;
                bd    = img[i];
                bl    = has_last && (i == nb - 1);
                start = poke && (i == 1);
                xfer  = v && br;
                @(negedge clk);
                if (xfer) i++;
                cyc++;
            end
            bv    = 1'b0;
            bl    = 1'b0;
            start = 1'b0;
            while (!done && cyc < lim) begin
                @(negedge clk);
                cyc++;
            end
            check(nm("done"), 64'(done), 64'd1);
            check(nm("word_count"), 64'(wc), 64'(nw));
            check(nm("end_flags"), {62'd0, busy, br}, 64'd0);
            check(nm("pending_writes"), 64'(exp_addr.size()), 64'd0);
            $display("c%0d load bytes=%0d words=%0d mode=%0d word_count=%0d",
                     gi, nb, nw, mode, wc);
            if (consumed < nb) begin
                bv = 1'b1;
                bd = img[consumed];
                repeat (3) begin
                    @(negedge clk);
                    check(nm("excess_not_ready"), 64'(br), 64'd0);
                end
                bv = 1'b0;
            end
        endtask

        task automatic reset_mid();
            int npre;
            logic [7:0] q[$];
            npre = $urandom_range(0, B - 1);
            pulse_start();
            for (int k = 0; k < npre; k++) begin
                bv = 1'b1;
                bd = 8'h99;
                @(negedge clk);
            end
            bv  = 1'b0;
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check(nm("mid_reset_outputs"),
                  {58'd0, br, ms, busy, done, |ma, |wc} | 64'(mi), 64'd0);
            $display("c%0d reset after %0d bytes", gi, npre);
            q = '{8'h11, 8'h22};
            run_load(q, 1'b1, 0, 1'b0);
        endtask

        initial begin
            logic [7:0] q[$];
            rst   = 1'b1;
            start = 1'b0;
            bv    = 1'b0;
            bd    = 8'h00;
            bl    = 1'b0;
            repeat (3) @(negedge clk);
            check(nm("reset_outputs"),
                  {58'd0, br, ms, busy, done, |ma, |wc} | 64'(mi), 64'd0);
            rst    = 1'b0;
            mon_en = 1'b1;

            q = '{8'h34, 8'h12, 8'h78, 8'h56};
            run_load(q, 1'b1, 0, 1'b0);
            q = '{8'hAB, 8'hCD, 8'hEF};
            run_load(q, 1'b1, 0, 1'b1);

            q.delete();
            for (int k = 0; k < D * B + 2; k++) q.push_back(8'($urandom));
            run_load(q, 1'b0, 0, 1'b0);

            q.delete();
            for (int k = 0; k < 8; k++) q.push_back(8'($urandom));
            run_load(q, 1'b1, 1, 1'b0);

            reset_mid();

            for (int t = 0; t < 6; t++) begin
                q.delete();
                for (int k = 0; k < int'($urandom_range(1, 12)); k++) q.push_back(8'($urandom));
                run_load(q, 1'b1, 2, 1'($urandom_range(0, 1)));
            end
            fin = 1'b1;
        end
    end

    initial begin
        int cyc;
        cyc = 0;
        while (!(g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin) && cyc < 90000) begin
            @(posedge clk);
            cyc++;
        end
        if (cyc >= 90000) begin
            total++;
            bad++;
            $display("FAIL global_timeout actual=%0d cycles required=all configs finished", cyc);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
